// File: rtl/bulk_line_arbiter.sv
// bulk_line_arbiter: round-robin share of one bulk line-transfer port
// between the icache refill (port 0) and dcache refill/writeback (port 1).
module bulk_line_arbiter #(
    parameter int LINE_SIZE = 8,
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 64
) (
    input  logic                            clk,
    input  logic                            rst,

    input  logic                            m0_req_valid,
    output logic                            m0_req_ready,
    input  logic                            m0_req_write,
    input  logic [ADDR_W-1:0]               m0_req_addr,
    input  logic [LINE_SIZE*DATA_W-1:0]     m0_req_wdata,
    input  logic [LINE_SIZE*DATA_W/8-1:0]   m0_req_wstrb,
    output logic                            m0_resp_valid,
    output logic [LINE_SIZE*DATA_W-1:0]     m0_resp_rdata,

    input  logic                            m1_req_valid,
    output logic                            m1_req_ready,
    input  logic                            m1_req_write,
    input  logic [ADDR_W-1:0]               m1_req_addr,
    input  logic [LINE_SIZE*DATA_W-1:0]     m1_req_wdata,
    input  logic [LINE_SIZE*DATA_W/8-1:0]   m1_req_wstrb,
    output logic                            m1_resp_valid,
    output logic [LINE_SIZE*DATA_W-1:0]     m1_resp_rdata,

    output logic                            s_req_valid,
    input  logic                            s_req_ready,
    output logic                            s_req_write,
    output logic [ADDR_W-1:0]               s_req_addr,
    output logic [LINE_SIZE*DATA_W-1:0]     s_req_wdata,
    output logic [LINE_SIZE*DATA_W/8-1:0]   s_req_wstrb,
    input  logic                            s_resp_valid,
    input  logic [LINE_SIZE*DATA_W-1:0]     s_resp_rdata,

    output logic                            grant_owner,
    output logic                            spurious_resp
);

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_WAIT_RESP
    } arb_state_t;

    arb_state_t state;
    arb_state_t state_nxt;
    logic       owner;
    logic       owner_nxt;
    logic       last_grant;
    logic       last_grant_nxt;
    logic       spurious_q;
    logic       winner;
    logic       own_valid;
    logic       own_write;

    // Owner's request lines; payload is passed through, never buffered.
    assign own_valid   = owner ? m1_req_valid : m0_req_valid;
    assign own_write   = owner ? m1_req_write : m0_req_write;
    assign s_req_write = own_write;
    assign s_req_addr  = owner ? m1_req_addr  : m0_req_addr;
    assign s_req_wdata = owner ? m1_req_wdata : m0_req_wdata;
    assign s_req_wstrb = owner ? m1_req_wstrb : m0_req_wstrb;

    // Read data fans out to both ports; only the valid pulse is steered.
    assign m0_resp_rdata = s_resp_rdata;
    assign m1_resp_rdata = s_resp_rdata;

    assign grant_owner   = owner;
    assign spurious_resp = spurious_q;

    // A lone requester wins; on a tie the port not granted last time wins.
    assign winner = (m0_req_valid && m1_req_valid) ? ~last_grant
                                                   : m1_req_valid;

    // State, grant history and sticky spurious-response flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB_IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            spurious_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_grant <= last_grant_nxt;
            if (s_resp_valid && (state != ARB_WAIT_RESP)) begin
                spurious_q <= 1'b1;
            end
        end
    end

    // Next-state logic and handshake steering.
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_grant_nxt = last_grant;
        s_req_valid    = 1'b0;
        m0_req_ready   = 1'b0;
        m1_req_ready   = 1'b0;
        m0_resp_valid  = 1'b0;
        m1_resp_valid  = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                if (m0_req_valid || m1_req_valid) begin
                    owner_nxt      = winner;
                    last_grant_nxt = winner;
                    state_nxt      = ARB_REQ;
                end
            end
            ARB_REQ: begin
                s_req_valid  = own_valid;
                m0_req_ready = ~owner & s_req_ready;
                m1_req_ready =  owner & s_req_ready;
                if (!own_valid) begin
                    state_nxt = ARB_IDLE;
                end else if (s_req_ready) begin
                    // Writes are posted: no response will follow.
                    state_nxt = own_write ? ARB_IDLE : ARB_WAIT_RESP;
                end
            end
            ARB_WAIT_RESP: begin
                if (s_resp_valid) begin
                    m0_resp_valid = ~owner;
                    m1_resp_valid =  owner;
                    state_nxt     = ARB_IDLE;
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bulk_line_arbiter.sv
// tb_bulk_line_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level arbitration model.
module tb_bulk_line_arbiter;

    localparam int LS = 8;
    localparam int DW = 64;
    localparam int AW = 64;
    localparam int LW = LS * DW;
    localparam int SW = LW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          rv [2];
    logic          rw [2];
    logic [AW-1:0] ra [2];
    logic [LW-1:0] rd [2];
    logic [SW-1:0] rs [2];
    logic          m0_req_ready, m1_req_ready;
    logic          m0_resp_valid, m1_resp_valid;
    logic [LW-1:0] m0_resp_rdata, m1_resp_rdata;
    logic          s_req_valid, s_req_ready, s_req_write;
    logic [AW-1:0] s_req_addr;
    logic [LW-1:0] s_req_wdata;
    logic [SW-1:0] s_req_wstrb;
    logic          s_resp_valid;
    logic [LW-1:0] s_resp_rdata;
    logic          grant_owner, spurious_resp;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bulk_line_arbiter #(.LINE_SIZE(LS), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .m0_req_valid (rv[0]),
        .m0_req_ready (m0_req_ready),
        .m0_req_write (rw[0]),
        .m0_req_addr  (ra[0]),
        .m0_req_wdata (rd[0]),
        .m0_req_wstrb (rs[0]),
        .m0_resp_valid(m0_resp_valid),
        .m0_resp_rdata(m0_resp_rdata),
        .m1_req_valid (rv[1]),
        .m1_req_ready (m1_req_ready),
        .m1_req_write (rw[1]),
        .m1_req_addr  (ra[1]),
        .m1_req_wdata (rd[1]),
        .m1_req_wstrb (rs[1]),
        .m1_resp_valid(m1_resp_valid),
        .m1_resp_rdata(m1_resp_rdata),
        .s_req_valid  (s_req_valid),
        .s_req_ready  (s_req_ready),
        .s_req_write  (s_req_write),
        .s_req_addr   (s_req_addr),
        .s_req_wdata  (s_req_wdata),
        .s_req_wstrb  (s_req_wstrb),
        .s_resp_valid (s_resp_valid),
        .s_resp_rdata (s_resp_rdata),
        .grant_owner  (grant_owner),
        .spurious_resp(spurious_resp)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_line(output logic [LW-1:0] v);
        for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    endtask

    task automatic new_req(input int p, input logic wr);
        logic [LW-1:0] l;
        logic [LW-1:0] s;
        rand_line(l);
        rand_line(s);
        rv[p] = 1'b1;
        rw[p] = wr;
        ra[p] = {$urandom, $urandom} & ~64'h3f;
        rd[p] = l;
        rs[p] = s[SW-1:0];
    endtask

    task automatic clear_inputs();
        for (int p = 0; p < 2; p++) begin
            rv[p] = 1'b0;
            rw[p] = 1'b0;
            ra[p] = '0;
            rd[p] = '0;
            rs[p] = '0;
        end
        s_req_ready  = 1'b0;
        s_resp_valid = 1'b0;
        s_resp_rdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        #3;
        n_checks++;
        if ({s_req_valid, m0_req_ready, m1_req_ready,
             m0_resp_valid, m1_resp_valid} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 00000",
                     {s_req_valid, m0_req_ready, m1_req_ready,
                      m0_resp_valid, m1_resp_valid});
        end
        n_checks++;
        if (spurious_resp !== 1'b0 || grant_owner !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: spurious=%b owner=%b want 0 0",
                     spurious_resp, grant_owner);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (s_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: s_req_valid=%b want 0", s_req_valid);
        end
    endtask

    task automatic test_tie();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        clear_inputs();
        rv[0] = 1'b1; ra[0] = 64'h3000;
        rv[1] = 1'b1; ra[1] = 64'h4000;
        tick();
        n_checks++;
        if (grant_owner !== 1'b0 || s_req_addr !== 64'h3000
            || s_req_valid !== 1'b1 || m1_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_first: owner=%b addr=%h valid=%b want 0 3000 1",
                     grant_owner, s_req_addr, s_req_valid);
        end
        s_req_ready = 1'b1;
        tick();
        rv[0] = 1'b0;
        s_req_ready = 1'b0;
        #1;
        n_checks++;
        if (s_req_valid !== 1'b0 || m1_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_wait: s_req_valid=%b m1_ready=%b want 0 0",
                     s_req_valid, m1_req_ready);
        end
        tick();
        tick();
        s_resp_valid = 1'b1;
        #1;
        n_checks++;
        if (m0_resp_valid !== 1'b1 || m1_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_resp0: m0=%b m1=%b want 1 0",
                     m0_resp_valid, m1_resp_valid);
        end
        tick();
        s_resp_valid = 1'b0;
        #1;
        n_checks++;
        if (s_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_gap: s_req_valid=%b want 0", s_req_valid);
        end
        tick();
        n_checks++;
        if (grant_owner !== 1'b1 || s_req_addr !== 64'h4000
            || s_req_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL tie_second: owner=%b addr=%h want 1 4000",
                     grant_owner, s_req_addr);
        end
        s_req_ready = 1'b1;
        tick();
        rv[1] = 1'b0;
        s_req_ready = 1'b0;
        s_resp_valid = 1'b1;
        #1;
        n_checks++;
        if (m1_resp_valid !== 1'b1 || m0_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_resp1: m0=%b m1=%b want 0 1",
                     m0_resp_valid, m1_resp_valid);
        end
        tick();
        s_resp_valid = 1'b0;
    endtask

    task automatic test_single_read();
        logic [LW-1:0] pat;
        logic          bad;
        pat = {LS{64'hA5A5_A5A5_A5A5_A5A5}};
        rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 64'h1000;
        tick();
        n_checks++;
        if (s_req_valid !== 1'b1 || s_req_addr !== 64'h1000
            || s_req_write !== 1'b0 || m0_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_fwd: valid=%b addr=%h wr=%b rdy=%b want 1 1000 0 0",
                     s_req_valid, s_req_addr, s_req_write, m0_req_ready);
        end
        tick();
        tick();
        s_req_ready = 1'b1;
        #1;
        n_checks++;
        if (m0_req_ready !== 1'b1 || m1_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_ready: m0=%b m1=%b want 1 0",
                     m0_req_ready, m1_req_ready);
        end
        tick();
        rv[0] = 1'b0;
        s_req_ready = 1'b0;
        bad = 1'b0;
        repeat (20) begin
            #1;
            if (s_req_valid || m0_resp_valid || m1_resp_valid) bad = 1'b1;
            tick();
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_quiet_wait: activity=%b want 0", bad);
        end
        s_resp_valid = 1'b1;
        s_resp_rdata = pat;
        #1;
        n_checks++;
        if (m0_resp_valid !== 1'b1 || m1_resp_valid !== 1'b0
            || m0_resp_rdata !== pat) begin
            n_fail++;
            $display("FAIL rd_resp: m0=%b m1=%b data=%h want 1 0 %h",
                     m0_resp_valid, m1_resp_valid, m0_resp_rdata, pat);
        end
        tick();
        s_resp_valid = 1'b0;
        #1;
        n_checks++;
        if (m0_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_pulse: m0_resp_valid=%b want 0", m0_resp_valid);
        end
    endtask

    task automatic test_write_then_read();
        logic [LW-1:0] wd;
        rand_line(wd);
        rv[1] = 1'b1; rw[1] = 1'b1; ra[1] = 64'h2000;
        rd[1] = wd;   rs[1] = '1;
        tick();
        rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 64'h5000;
        #1;
        n_checks++;
        if (grant_owner !== 1'b1 || s_req_write !== 1'b1
            || s_req_addr !== 64'h2000) begin
            n_fail++;
            $display("FAIL wr_fwd: owner=%b wr=%b addr=%h want 1 1 2000",
                     grant_owner, s_req_write, s_req_addr);
        end
        n_checks++;
        if (s_req_wdata !== wd || s_req_wstrb !== {SW{1'b1}}) begin
            n_fail++;
            $display("FAIL wr_payload: wstrb=%h want all ones, wdata=%h",
                     s_req_wstrb, s_req_wdata);
        end
        s_req_ready = 1'b1;
        tick();
        rv[1] = 1'b0;
        s_req_ready = 1'b0;
        #1;
        n_checks++;
        if (s_req_valid !== 1'b0 || m1_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_posted: s_req_valid=%b m1_resp=%b want 0 0",
                     s_req_valid, m1_resp_valid);
        end
        tick();
        n_checks++;
        if (grant_owner !== 1'b0 || s_req_addr !== 64'h5000
            || s_req_write !== 1'b0 || s_req_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_then_rd: owner=%b addr=%h wr=%b want 0 5000 0",
                     grant_owner, s_req_addr, s_req_write);
        end
        s_req_ready = 1'b1;
        tick();
        rv[0] = 1'b0;
        s_req_ready = 1'b0;
        s_resp_valid = 1'b1;
        tick();
        s_resp_valid = 1'b0;
    endtask

    task automatic test_spurious_and_reset();
        s_resp_valid = 1'b1;
        #1;
        n_checks++;
        if (m0_resp_valid !== 1'b0 || m1_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL spur_fwd: m0=%b m1=%b want 0 0",
                     m0_resp_valid, m1_resp_valid);
        end
        tick();
        s_resp_valid = 1'b0;
        tick();
        n_checks++;
        if (spurious_resp !== 1'b1) begin
            n_fail++;
            $display("FAIL spur_flag: spurious_resp=%b want 1", spurious_resp);
        end
        rv[1] = 1'b1; rw[1] = 1'b0; ra[1] = 64'h6000;
        tick();
        s_req_ready = 1'b1;
        tick();
        rv[1] = 1'b0;
        s_req_ready = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({s_req_valid, m0_req_ready, m1_req_ready, m0_resp_valid,
             m1_resp_valid, spurious_resp, grant_owner} !== 7'b0) begin
            n_fail++;
            $display("FAIL async_reset: got %b want 0000000",
                     {s_req_valid, m0_req_ready, m1_req_ready, m0_resp_valid,
                      m1_resp_valid, spurious_resp, grant_owner});
        end
        tick();
        rst = 1'b0;
        rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 64'h7000;
        rv[1] = 1'b1; rw[1] = 1'b0; ra[1] = 64'h8000;
        tick();
        n_checks++;
        if (grant_owner !== 1'b0 || s_req_addr !== 64'h7000) begin
            n_fail++;
            $display("FAIL reset_tie: owner=%b addr=%h want 0 7000",
                     grant_owner, s_req_addr);
        end
    endtask

    // Randomized traffic. The model tracks transactions only: whether the
    // shared port is free, granted to a port, or awaiting that port's read.
    task automatic run_traffic(input int n_per_port, input bit contend);
        int   left [2];
        int   reads [2];
        int   resps [2];
        bit   done [2];
        int   grants [$];
        int   phase;
        int   cur;
        int   last;
        int   delay;
        int   cyc;
        logic e0, e1;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        clear_inputs();
        phase = 0;
        cur   = 0;
        last  = 1;
        delay = 0;
        cyc   = 0;
        for (int p = 0; p < 2; p++) begin
            left[p]  = n_per_port;
            reads[p] = 0;
            resps[p] = 0;
            done[p]  = 1'b0;
        end
        while ((left[0] + left[1] > 0 || rv[0] || rv[1] || phase != 0)
               && cyc < 4000) begin
            @(negedge clk);
            e0 = (phase == 2) && s_resp_valid && (cur == 0);
            e1 = (phase == 2) && s_resp_valid && (cur == 1);
            n_checks++;
            if (m0_resp_valid !== e0 || m1_resp_valid !== e1) begin
                n_fail++;
                $display("FAIL trf_resp_route: m0=%b m1=%b want %b %b",
                         m0_resp_valid, m1_resp_valid, e0, e1);
            end
            if (e0 || e1) begin
                n_checks++;
                if ((e0 ? m0_resp_rdata : m1_resp_rdata) !== s_resp_rdata) begin
                    n_fail++;
                    $display("FAIL trf_resp_data: port %0d data mismatch", cur);
                end
            end
            if (phase == 1) begin
                n_checks++;
                if (s_req_valid !== 1'b1 || int'(grant_owner) != cur
                    || s_req_addr !== ra[cur] || s_req_write !== rw[cur]
                    || s_req_wdata !== rd[cur] || s_req_wstrb !== rs[cur]) begin
                    n_fail++;
                    $display("FAIL trf_fwd: valid=%b owner=%b addr=%h want 1 %0d %h",
                             s_req_valid, grant_owner, s_req_addr, cur, ra[cur]);
                end
                n_checks++;
                if (m0_req_ready !== (cur == 0 && s_req_ready)
                    || m1_req_ready !== (cur == 1 && s_req_ready)) begin
                    n_fail++;
                    $display("FAIL trf_ready: m0=%b m1=%b owner %0d s_rdy=%b",
                             m0_req_ready, m1_req_ready, cur, s_req_ready);
                end
            end else begin
                n_checks++;
                if (s_req_valid !== 1'b0 || m0_req_ready !== 1'b0
                    || m1_req_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL trf_idle: valid=%b m0r=%b m1r=%b want 0 0 0",
                             s_req_valid, m0_req_ready, m1_req_ready);
                end
            end
            case (phase)
                0: if (rv[0] || rv[1]) begin
                    if (rv[0] && rv[1]) cur = 1 - last;
                    else cur = rv[1] ? 1 : 0;
                    last = cur;
                    grants.push_back(cur);
                    phase = 1;
                end
                1: if (s_req_ready) begin
                    done[cur] = 1'b1;
                    phase = rw[cur] ? 0 : 2;
                    delay = $urandom_range(0, 6);
                end
                default: if (s_resp_valid) begin
                    resps[cur]++;
                    phase = 0;
                end
            endcase
            @(posedge clk);
            #1;
            for (int p = 0; p < 2; p++) begin
                if (done[p]) begin
                    rv[p] = 1'b0;
                    done[p] = 1'b0;
                end
                if (!rv[p] && left[p] > 0 && (contend || $urandom_range(0, 2) == 0)) begin
                    new_req(p, contend ? 1'b0 : 1'($urandom_range(0, 1)));
                    if (!rw[p]) reads[p]++;
                    left[p]--;
                end
            end
            s_req_ready  = 1'($urandom_range(0, 1));
            s_resp_valid = 1'b0;
            if (phase == 2) begin
                if (delay == 0) begin
                    s_resp_valid = 1'b1;
                    rand_line(s_resp_rdata);
                end else begin
                    delay--;
                end
            end
            cyc++;
        end
        n_checks++;
        if (cyc >= 4000) begin
            n_fail++;
            $display("FAIL trf_timeout: cycles=%0d left=%0d/%0d", cyc, left[0], left[1]);
        end
        for (int p = 0; p < 2; p++) begin
            n_checks++;
            if (resps[p] != reads[p]) begin
                n_fail++;
                $display("FAIL trf_resp_count: port %0d got %0d want %0d",
                         p, resps[p], reads[p]);
            end
        end
        if (contend) begin
            n_checks++;
            if (grants.size() != 2 * n_per_port || grants[0] != 0) begin
                n_fail++;
                $display("FAIL cont_grants: count=%0d first=%0d want %0d 0",
                         grants.size(), grants[0], 2 * n_per_port);
            end
            for (int i = 1; i < grants.size(); i++) begin
                n_checks++;
                if (grants[i] == grants[i-1]) begin
                    n_fail++;
                    $display("FAIL cont_alternate: grant %0d port %0d repeats",
                             i, grants[i]);
                end
            end
        end
    endtask

    task automatic test_contention();
        run_traffic(6, 1'b1);
    endtask

    task automatic test_random_mix();
        run_traffic(20, 1'b0);
    endtask

    initial begin
        test_reset();
        test_tie();
        test_single_read();
        test_write_then_read();
        test_spurious_and_reset();
        test_contention();
        test_random_mix();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bulk_line_arbiter.md
Name: bulk_line_arbiter

Overview:
- Two-port arbiter that shares one downstream bulk line-transfer port between two cache-line requesters: port 0 (instruction cache refill) and port 1 (data cache refill/writeback).
- Sits between the caches and the bulk-read-to-AXI adapter.
- Grants one requester at a time with round-robin fairness and forwards its line request unchanged.
- Routes each read response back to the requester that issued it.
- Never has more than one transaction outstanding downstream.

Parameters:
- LINE_SIZE, 8, beats per cache line (power of two, ≥2).
- DATA_W, 64, bits per beat.
- ADDR_W, 64, request address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- m0_req_valid / m1_req_valid  in  1  requester n has a line request.
- m0_req_ready / m1_req_ready  out  1  request n accepted this cycle.
- m0_req_write / m1_req_write  in  1  1 = line write, 0 = line read.
- m0_req_addr / m1_req_addr  in  ADDR_W  line address.
- m0_req_wdata / m1_req_wdata  in  LINE_SIZE*DATA_W  write line, beat 0 in the LSBs.
- m0_req_wstrb / m1_req_wstrb  in  LINE_SIZE*DATA_W/8  write strobes.
- m0_resp_valid / m1_resp_valid  out  1  read line returned to requester n (1-cycle pulse).
- m0_resp_rdata / m1_resp_rdata  out  LINE_SIZE*DATA_W  read line.
- s_req_valid  out  1  downstream request valid.
- s_req_ready  in  1  downstream accepts.
- s_req_write  out  1.
- s_req_addr  out  ADDR_W.
- s_req_wdata  out  LINE_SIZE*DATA_W.
- s_req_wstrb  out  LINE_SIZE*DATA_W/8.
- s_resp_valid  in  1  downstream read line complete.
- s_resp_rdata  in  LINE_SIZE*DATA_W.
- grant_owner  out  1  index of the current or last granted requester (debug).
- spurious_resp  out  1  sticky: s_resp_valid seen outside ARB_WAIT_RESP.

Behaviour:
- Reset (async assert):
  - State goes to ARB_IDLE; owner=0; last_grant=1, so port 0 wins the first tie.
  - All valid/ready outputs go to 0; spurious_resp=0.
  - Any in-flight transaction is dropped and no response is forwarded.
  - The downstream block shares rst.
- Requester rule: once m_req_valid is raised, it and its payload are held stable until m_req_ready. The arbiter does not buffer payloads.
- State ARB_IDLE:
  - All ready outputs and s_req_valid are 0.
  - If either valid is high, pick the winner:
    - only one valid → that port;
    - both valid → the port != last_grant.
  - Register owner and last_grant←winner, then go to ARB_REQ. Arbitration latency is 1 cycle.
- State ARB_REQ:
  - s_req_* is a combinational mux of the owner's inputs.
  - s_req_valid = owner's req_valid.
  - Owner's req_ready = s_req_ready; the other port's ready = 0.
  - On handshake (s_req_valid & s_req_ready):
    - read → ARB_WAIT_RESP;
    - write → ARB_IDLE. Writes are posted; there is no response.
  - If the owner's valid drops before handshake (protocol violation), return to ARB_IDLE.
- State ARB_WAIT_RESP:
  - No requests are forwarded; both ready outputs are 0.
  - On s_req_... s_resp_valid: owner's resp_valid=1 for exactly that cycle, then → ARB_IDLE.
- Response data: m0_resp_rdata and m1_resp_rdata are both wired to s_resp_rdata; only resp_valid is steered.
- Spurious responses: s_resp_valid in ARB_IDLE or ARB_REQ is not forwarded and sets spurious_resp, which is cleared only by reset.
- Simultaneous events:
  - A new request arriving in the same cycle as s_resp_valid is arbitrated in the following ARB_IDLE cycle.
  - Minimum gap between back-to-back grants: 1 idle cycle.
- Fairness: with both ports continuously requesting, grants strictly alternate 0,1,0,1. No requester waits longer than one other transaction.
- Ordering: a downstream write is serialized before any later read because the downstream deasserts s_req_ready until the write drains. The arbiter adds no reordering.

Test Plan:
- Single read: m0 read addr 0x1000, downstream ready after 2 cycles, resp 20 cycles later with pattern 0xA5.. → s_req_addr=0x1000 and write=0; m0_resp_valid pulses 1 cycle with data 0xA5..; m1_resp_valid stays 0.
- Tie after reset: m0 and m1 both request reads in the same cycle → m0 granted first; m1 granted in the idle cycle after m0's response; grant_owner 0 then 1.
- Sustained contention: both ports issue 6 back-to-back reads each → grants alternate 0,1,...; each port receives exactly 6 responses, each tagged to the correct port.
- Posted write then read: m1 writes line 0x2000 (wstrb all 1s), m0 then reads → write is forwarded with identical wdata/wstrb; arbiter returns to ARB_IDLE on write handshake with no m1_resp_valid; the read is granted next.
- Spurious response and reset: inject s_resp_valid while in ARB_IDLE → no m*_resp_valid and spurious_resp=1. Assert rst asynchronously mid-ARB_WAIT_RESP → all outputs 0 immediately, spurious_resp=0, and the next tie grants port 0.
